// File: rtl/dac_spi_receiver.sv
// AD5662-style SPI write-frame receiver: synchronizes the async SPI pins into dataclk,
// shifts in a frame on SCLK falling edges and publishes the 16-bit code plus power-down bits.
module dac_spi_receiver #(
   parameter int unsigned FRAME_BITS  = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        dataclk,
   input  logic        reset,
   input  logic        en,
   input  logic        DAC_SYNC,
   input  logic        DAC_SCLK,
   input  logic        DAC_DIN,
   output logic [15:0] data_out,
   output logic [15:0] data_signed,
   output logic [1:0]  pd_mode,
   output logic        data_valid,
   output logic        abort_err,
   output logic        overrun_err,
   output logic        busy,
   output logic [15:0] frame_count
);

   localparam logic [4:0] LastCnt = 5'(FRAME_BITS - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   logic [SYNC_STAGES-1:0] sync_meta_q, sclk_meta_q, din_meta_q;
   logic                   sclk_hist_q;
   logic                   sync_s, sclk_s, din_s, sclk_fall;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [15:0] data_out_q, data_out_d;
   logic [15:0] data_signed_q, data_signed_d;
   logic [1:0]  pd_mode_q, pd_mode_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        data_valid_q, data_valid_d;
   logic        abort_err_q, abort_err_d;
   logic        overrun_err_q, overrun_err_d;

   logic        take_bit;
   logic [4:0]  cnt_base;
   logic [23:0] shift_base;

   // SYNC idles high and SCLK low out of reset so no false frame start or edge appears.
   always_ff @(posedge dataclk) begin
      if (reset) begin
         sync_meta_q <= '1;
         sclk_meta_q <= '0;
         din_meta_q  <= '0;
         sclk_hist_q <= 1'b0;
      end else begin
         sync_meta_q[0] <= DAC_SYNC;
         sclk_meta_q[0] <= DAC_SCLK;
         din_meta_q[0]  <= DAC_DIN;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_meta_q[i] <= sync_meta_q[i-1];
            sclk_meta_q[i] <= sclk_meta_q[i-1];
            din_meta_q[i]  <= din_meta_q[i-1];
         end
         sclk_hist_q <= sclk_s;
      end
   end

   assign sync_s    = sync_meta_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_meta_q[SYNC_STAGES-1];
   assign din_s     = din_meta_q[SYNC_STAGES-1];
   assign sclk_fall = sclk_hist_q & ~sclk_s;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shift_d       = shift_q;
      data_out_d    = data_out_q;
      data_signed_d = data_signed_q;
      pd_mode_d     = pd_mode_q;
      frame_count_d = frame_count_q;
      data_valid_d  = 1'b0;
      abort_err_d   = 1'b0;
      overrun_err_d = 1'b0;
      take_bit      = 1'b0;
      cnt_base      = cnt_q;
      shift_base    = shift_q;

      if (!en) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!sync_s) begin
                  // An edge coincident with the SYNC fall is the first (MSB) bit.
                  state_d    = StShift;
                  cnt_d      = '0;
                  shift_d    = '0;
                  cnt_base   = '0;
                  shift_base = '0;
                  take_bit   = sclk_fall;
               end
            end
            StShift: begin
               if (sync_s) begin
                  state_d     = StIdle;
                  abort_err_d = 1'b1;
               end else begin
                  take_bit = sclk_fall;
               end
            end
            StDone: begin
               if (sync_s) begin
                  state_d = StIdle;
               end else if (sclk_fall) begin
                  overrun_err_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase

         if (take_bit) begin
            shift_d = (shift_base << 1) | 24'(din_s);
            cnt_d   = cnt_base + 5'd1;
            if (cnt_base == LastCnt) begin
               state_d       = StDone;
               data_out_d    = shift_d[15:0];
               data_signed_d = {~shift_d[15], shift_d[14:0]};
               pd_mode_d     = shift_d[17:16];
               frame_count_d = frame_count_q + 16'd1;
               data_valid_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge dataclk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         shift_q       <= '0;
         data_out_q    <= '0;
         data_signed_q <= '0;
         pd_mode_q     <= '0;
         frame_count_q <= '0;
         data_valid_q  <= 1'b0;
         abort_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         data_out_q    <= data_out_d;
         data_signed_q <= data_signed_d;
         pd_mode_q     <= pd_mode_d;
         frame_count_q <= frame_count_d;
         data_valid_q  <= data_valid_d;
         abort_err_q   <= abort_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign data_out    = data_out_q;
   assign data_signed = data_signed_q;
   assign pd_mode     = pd_mode_q;
   assign frame_count = frame_count_q;
   assign data_valid  = data_valid_q;
   assign abort_err   = abort_err_q;
   assign overrun_err = overrun_err_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed bench for dac_spi_receiver: bit-banged SPI frames at 40 dataclk per bit,
// pulse counters sampled after each rising edge, immediate assertions at each check.
module tb_dac_spi_receiver;

   logic        dataclk;
   logic        reset;
   logic        en;
   logic        DAC_SYNC;
   logic        DAC_SCLK;
   logic        DAC_DIN;
   logic [15:0] data_out;
   logic [15:0] data_signed;
   logic [1:0]  pd_mode;
   logic        data_valid;
   logic        abort_err;
   logic        overrun_err;
   logic        busy;
   logic [15:0] frame_count;

   int n_cmp = 0;
   int n_bad = 0;
   int dv_n = 0, ab_n = 0, ov_n = 0, multi_n = 0;
   int dv0, ab0, ov0;
   logic [2:0] tdv;

   dac_spi_receiver #(
      .FRAME_BITS (24),
      .SYNC_STAGES(2)
   ) dut (
      .dataclk    (dataclk),
      .reset      (reset),
      .en         (en),
      .DAC_SYNC   (DAC_SYNC),
      .DAC_SCLK   (DAC_SCLK),
      .DAC_DIN    (DAC_DIN),
      .data_out   (data_out),
      .data_signed(data_signed),
      .pd_mode    (pd_mode),
      .data_valid (data_valid),
      .abort_err  (abort_err),
      .overrun_err(overrun_err),
      .busy       (busy),
      .frame_count(frame_count)
   );

   initial dataclk = 1'b0;
   always #5 dataclk = ~dataclk;

   // Pulse counters sampled well after the rising edge so outputs have settled.
   always @(posedge dataclk) begin
      #2;
      if (data_valid)  dv_n++;
      if (abort_err)   ab_n++;
      if (overrun_err) ov_n++;
      if ((int'(data_valid) + int'(abort_err) + int'(overrun_err)) > 1) multi_n++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      dv0 = dv_n;
      ab0 = ab_n;
      ov0 = ov_n;
   endtask

   task automatic frame_open();
      DAC_SYNC = 1'b0;
      repeat (10) @(negedge dataclk);
   endtask

   task automatic frame_close();
      repeat (10) @(negedge dataclk);
      DAC_SYNC = 1'b1;
      repeat (10) @(negedge dataclk);
   endtask

   // Each bit: SCLK high 20 cycles with DIN set, then low 20 cycles. tdv records data_valid
   // on the three negedges following the first rising edge that sees SCLK low.
   task automatic drive_bits(input logic [23:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         DAC_SCLK = 1'b1;
         if (i < 24) DAC_DIN = w[23-i];
         else        DAC_DIN = 1'b0;
         repeat (20) @(negedge dataclk);
         DAC_SCLK = 1'b0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge dataclk);
            if (c <= 3) tdv[c-1] = data_valid;
         end
      end
   endtask

   task automatic send_frame(input logic [23:0] w);
      frame_open();
      drive_bits(w, 24);
      frame_close();
   endtask

   initial begin
      reset    = 1'b1;
      en       = 1'b1;
      DAC_SYNC = 1'b1;
      DAC_SCLK = 1'b0;
      DAC_DIN  = 1'b0;
      tdv      = '0;
      repeat (5) @(negedge dataclk);
      chk("rst_data_out", 32'(data_out), 32'h0000);
      chk("rst_data_signed", 32'(data_signed), 32'h0000);
      chk("rst_pd_mode", 32'(pd_mode), 32'h0);
      chk("rst_frame_count", 32'(frame_count), 32'h0000);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_data_valid", 32'(data_valid), 32'h0);
      reset = 1'b0;
      repeat (5) @(negedge dataclk);

      // Frame 0x00_8000 with latency check on the final bit.
      snap();
      frame_open();
      drive_bits(24'h008000, 24);
      chk("f1_latency", 32'(tdv), 32'h4);
      chk("f1_busy_done", 32'(busy), 32'h1);
      frame_close();
      chk("f1_valid_cnt", 32'(dv_n - dv0), 32'd1);
      chk("f1_data_out", 32'(data_out), 32'h8000);
      chk("f1_data_signed", 32'(data_signed), 32'h0000);
      chk("f1_pd_mode", 32'(pd_mode), 32'h0);
      chk("f1_frame_count", 32'(frame_count), 32'd1);
      chk("f1_busy_idle", 32'(busy), 32'h0);

      send_frame(24'h011234);
      chk("f2_pd_mode", 32'(pd_mode), 32'h1);
      chk("f2_data_out", 32'(data_out), 32'h1234);
      chk("f2_data_signed", 32'(data_signed), 32'h9234);
      chk("f2_frame_count", 32'(frame_count), 32'd2);

      // Bits 23:18 set; only 17:0 matter.
      send_frame(24'hFE5678);
      chk("f3_pd_mode", 32'(pd_mode), 32'h2);
      chk("f3_data_out", 32'(data_out), 32'h5678);
      chk("f3_data_signed", 32'(data_signed), 32'hD678);
      chk("f3_frame_count", 32'(frame_count), 32'd3);

      // Abort after 10 edges.
      snap();
      frame_open();
      drive_bits(24'hFFFFFF, 10);
      frame_close();
      chk("abort_cnt", 32'(ab_n - ab0), 32'd1);
      chk("abort_no_valid", 32'(dv_n - dv0), 32'd0);
      chk("abort_data_out", 32'(data_out), 32'h5678);
      chk("abort_frame_count", 32'(frame_count), 32'd3);
      send_frame(24'h00FFFF);
      chk("post_abort_data_out", 32'(data_out), 32'hFFFF);
      chk("post_abort_signed", 32'(data_signed), 32'h7FFF);
      chk("post_abort_frame_count", 32'(frame_count), 32'd4);

      // 26 edges inside one SYNC-low window.
      snap();
      frame_open();
      drive_bits(24'h00ABCD, 26);
      frame_close();
      chk("ovr_valid_cnt", 32'(dv_n - dv0), 32'd1);
      chk("ovr_overrun_cnt", 32'(ov_n - ov0), 32'd2);
      chk("ovr_abort_cnt", 32'(ab_n - ab0), 32'd0);
      chk("ovr_data_out", 32'(data_out), 32'hABCD);
      chk("ovr_frame_count", 32'(frame_count), 32'd5);

      // Reset after 12 edges.
      frame_open();
      drive_bits(24'hFFFFFF, 12);
      snap();
      reset    = 1'b1;
      DAC_SYNC = 1'b1;
      repeat (10) @(negedge dataclk);
      chk("rst_mid_pulses", 32'((dv_n - dv0) + (ab_n - ab0) + (ov_n - ov0)), 32'd0);
      chk("rst_mid_frame_count", 32'(frame_count), 32'd0);
      reset = 1'b0;
      repeat (5) @(negedge dataclk);
      snap();
      send_frame(24'h000001);
      chk("after_rst_data_out", 32'(data_out), 32'h0001);
      chk("after_rst_signed", 32'(data_signed), 32'h8001);
      chk("after_rst_frame_count", 32'(frame_count), 32'd1);
      chk("after_rst_errs", 32'((ab_n - ab0) + (ov_n - ov0)), 32'd0);

      // en dropped mid-frame: silent abort.
      snap();
      frame_open();
      drive_bits(24'h00AAAA, 5);
      en = 1'b0;
      repeat (5) @(negedge dataclk);
      frame_close();
      en = 1'b1;
      repeat (5) @(negedge dataclk);
      chk("en_abort_silent", 32'(ab_n - ab0), 32'd0);
      chk("en_no_valid", 32'(dv_n - dv0), 32'd0);
      chk("en_frame_count", 32'(frame_count), 32'd1);

      // Stand in for 65535 prior frames, then one more wraps the counter.
      force dut.frame_count_q = 16'hFFFF;
      repeat (3) @(negedge dataclk);
      release dut.frame_count_q;
      repeat (2) @(negedge dataclk);
      snap();
      send_frame(24'h000002);
      chk("wrap_frame_count", 32'(frame_count), 32'h0000);
      chk("wrap_valid_cnt", 32'(dv_n - dv0), 32'd1);
      chk("wrap_data_out", 32'(data_out), 32'h0002);

      chk("pulses_exclusive", 32'(multi_n), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dac_spi_receiver.md
DAC_SPI_RECEIVER -- requirements
Module: dac_spi_receiver

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 24; number of SCLK falling edges in one complete AD5662 write frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2; number of synchronizer flops on each SPI input before edge detection.
REQ-003 SHALL have port dataclk, input, 1, system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous, active-high, sampled on dataclk.
REQ-005 SHALL have port en, input, 1, receive enable; when low, frames are ignored.
REQ-006 SHALL have port DAC_SYNC, input, 1, frame select from the transmitter; active low, asynchronous to dataclk.
REQ-007 SHALL have port DAC_SCLK, input, 1, serial clock from the transmitter; asynchronous.
REQ-008 SHALL have port DAC_DIN, input, 1, serial data, MSB first; asynchronous.
REQ-009 SHALL have port data_out, output, 16, last complete frame's data word in offset binary.
REQ-010 SHALL have port data_signed, output, 16, data_out with its MSB inverted (two's complement).
REQ-011 SHALL have port pd_mode, output, 2, frame bits 17:16 (power-down control).
REQ-012 SHALL have port data_valid, output, 1, one-cycle pulse when data_out, data_signed and pd_mode update.
REQ-013 SHALL have port abort_err, output, 1, one-cycle pulse when a frame ends early.
REQ-014 SHALL have port overrun_err, output, 1, one-cycle pulse for each extra SCLK falling edge after a complete frame.
REQ-015 SHALL have port busy, output, 1, high while the state is SHIFT or DONE.
REQ-016 SHALL have port frame_count, output, 16, count of valid frames; wraps at 16 bits.

Function
REQ-017 SHALL pass DAC_SYNC, DAC_SCLK and DAC_DIN through SYNC_STAGES flops each, plus one history flop on SCLK; a falling edge is detected when the synchronized SCLK is 0 and its history is 1.
REQ-018 SHALL implement three states. IDLE: SYNC high. SHIFT: collecting bits. DONE: FRAME_BITS edges received, waiting for SYNC to rise.
REQ-019 SHALL move IDLE->SHIFT, and clear the bit counter and shift register, in the cycle the synchronized SYNC is low.
REQ-020 SHALL, for each detected falling edge in SHIFT with synchronized SYNC low, shift the synchronized DIN into a 24-bit shift register LSB-first position (MSB first on the wire) and increment a 5-bit counter.
REQ-021 SHALL, on the FRAME_BITS-th edge, enter DONE, load data_out=shift[15:0], data_signed={~shift[15],shift[14:0]}, pd_mode=shift[17:16], pulse data_valid, and increment frame_count (0xFFFF->0x0000).
REQ-022 SHALL register data_valid at dataclk edge E+SYNC_STAGES, where E is the first edge sampling raw SCLK low for the final bit; with defaults, this is 2 edges after E.
REQ-023 SHALL ignore frame bits 23:18.
REQ-024 SHALL, if synchronized SYNC is high in SHIFT, return to IDLE and pulse abort_err, with no data_valid, outputs unchanged and frame_count unchanged.
REQ-025 SHALL, in DONE, pulse overrun_err for every detected falling edge and keep outputs unchanged; synchronized SYNC high returns to IDLE with no error.
REQ-026 SHALL ignore SCLK edges in IDLE.
REQ-027 SHALL, if SYNC rise and SCLK fall are detected in the same cycle, give SYNC priority: the edge is not counted, and abort_err pulses if in SHIFT.
REQ-028 SHALL, if SYNC fall and SCLK fall are detected in the same cycle in IDLE, enter SHIFT and count that edge as bit 23.
REQ-029 SHALL, when en is low, force IDLE and suppress all pulses; deasserting en mid-frame aborts silently with no abort_err.
REQ-030 SHALL never assert data_valid, abort_err and overrun_err in the same cycle.

Reset
REQ-031 SHALL, on reset, set state to IDLE and clear the counter and shift register; data_out=0x0000, data_signed=0x0000, pd_mode=0, data_valid=0, abort_err=0, overrun_err=0, busy=0, frame_count=0.
REQ-032 SHALL reset the SYNC synchronizer to 1, and the SCLK synchronizer and history flop to 0, so that no spurious edge or frame start occurs after reset.
REQ-033 SHALL, when reset is asserted mid-frame, discard the frame, produce no pulses, and require a fresh SYNC fall to start the next frame.

Verification
REQ-034 SHALL cover: 24-bit frame 0x00_8000 at 1 bit per 40 dataclk -> data_valid once, data_out=0x8000, data_signed=0x0000, pd_mode=0, frame_count=1.
REQ-035 SHALL cover: frame 0x01_1234 -> pd_mode=01, data_out=0x1234, data_signed=0x9234.
REQ-036 SHALL cover: SYNC raised after 10 edges -> abort_err pulse, data_out and frame_count unchanged; the next full frame 0x00_FFFF decodes to 0xFFFF.
REQ-037 SHALL cover: 26 edges in one SYNC-low window -> data_valid once at edge 24, two overrun_err pulses, data_out holds the 24-edge value.
REQ-038 SHALL cover: reset asserted after 12 edges, then released, then a full frame 0x00_0001 -> no pulses during reset, then data_out=0x0001, frame_count=1.
REQ-039 SHALL cover: frame_count preloaded by 65535 valid frames, then one more frame -> frame_count=0x0000, data_valid asserted.
